// File: rtl/monpro_pkg.sv
// -----------------------------------------------------------------------------
// monpro_pkg
// Shared constants and encodings for the MonPro operand loader.
//   DATA_WIDTH / ADDR_WIDTH / NUM_WORDS : operand geometry (NUM_WORDS = 2**ADDR_WIDTH)
//   SEL_M / SEL_E / SEL_N / SEL_RSVD    : host write-port operand select codes
//   loader_state_t                      : loader FSM state encoding
// -----------------------------------------------------------------------------
package monpro_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_WORDS  = 32;

    localparam logic [1:0] SEL_M    = 2'd0;
    localparam logic [1:0] SEL_E    = 2'd1;
    localparam logic [1:0] SEL_N    = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } loader_state_t;

endpackage

// File: rtl/operand_bank.sv
// -----------------------------------------------------------------------------
// operand_bank
// One NUM_WORDS x DATA_WIDTH operand buffer with a per-word valid bitmap.
//   clk, reset (async, active-low)
//   wr_en, wr_addr, wr_data : write port (stores word, sets its valid bit)
//   clear                   : synchronous clear of the whole valid bitmap
//   rd_addr, rd_data        : asynchronous read port
//   all_valid, lsw_valid    : bitmap flags, already including a write
//                             presented in the same cycle
// Optional build macro MONPRO_LOADER_ZERO_FILL_EN: each write invalidates all
// higher words of the bank, and invalid words read back as zero.
// -----------------------------------------------------------------------------
module operand_bank #(
    parameter int DATA_WIDTH = monpro_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = monpro_pkg::ADDR_WIDTH,
    parameter int NUM_WORDS  = monpro_pkg::NUM_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  all_valid,
    output logic                  lsw_valid
);

    logic [DATA_WIDTH-1:0] mem_r [NUM_WORDS];
    logic [NUM_WORDS-1:0]  valid_r;
    logic [NUM_WORDS-1:0]  valid_upd_s;

    // Word storage; contents are meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Bitmap as it will look after this cycle's write (used for same-cycle go).
    always_comb begin
        valid_upd_s = valid_r;
        if (wr_en) begin
`ifdef MONPRO_LOADER_ZERO_FILL_EN
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (i > int'(wr_addr)) begin
                    valid_upd_s[i] = 1'b0;
                end else begin
                    valid_upd_s[i] = valid_r[i];
                end
            end
`endif
            valid_upd_s[wr_addr] = 1'b1;
        end else begin
            valid_upd_s = valid_r;
        end
    end

    // Valid bitmap register; clear takes priority over a write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= {NUM_WORDS{1'b0}};
        end else if (clear) begin
            valid_r <= {NUM_WORDS{1'b0}};
        end else begin
            valid_r <= valid_upd_s;
        end
    end

`ifdef MONPRO_LOADER_ZERO_FILL_EN
    assign rd_data = valid_r[rd_addr] ? mem_r[rd_addr] : {DATA_WIDTH{1'b0}};
`else
    assign rd_data = mem_r[rd_addr];
`endif

    assign all_valid = &valid_upd_s;
    assign lsw_valid = valid_upd_s[0];

endmodule

// File: rtl/monpro_operand_loader.sv
// -----------------------------------------------------------------------------
// monpro_operand_loader
// Buffers the MonPro operands m, e and n from a host word-write port and, on
// go, streams them LSW first, one word per clock, framed by start_input.
//   clk, reset (async, active-low)
//   wr_valid/wr_ready, wr_sel, wr_addr, wr_data : host write port
//   go / go_err                                 : start request / rejection pulse
//   busy                                        : high while priming or streaming
//   start_input, m_input, e_input, n_input      : registered MonPro feed
//   stream_done                                 : pulse the cycle after the last word
// Optional build macro MONPRO_LOADER_ZERO_FILL_EN: go needs only word 0 of each
// bank, and unwritten words stream as zero.
// Timing: go accepted at an edge -> one PRIME cycle (start_input=1, data 0),
// then NUM_WORDS data cycles, then stream_done with all bitmaps cleared.
// -----------------------------------------------------------------------------
module monpro_operand_loader #(
    parameter int DATA_WIDTH = monpro_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = monpro_pkg::ADDR_WIDTH,
    parameter int NUM_WORDS  = monpro_pkg::NUM_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [1:0]            wr_sel,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  go,
    output logic                  go_err,
    output logic                  busy,
    output logic                  start_input,
    output logic [DATA_WIDTH-1:0] m_input,
    output logic [DATA_WIDTH-1:0] e_input,
    output logic [DATA_WIDTH-1:0] n_input,
    output logic                  stream_done
);

    import monpro_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(32'd1);

    loader_state_t         state_r, state_s;
    logic [ADDR_WIDTH-1:0] idx_r, idx_s, rd_addr_s;
    logic                  wr_fire_s, wr_en_m_s, wr_en_e_s, wr_en_n_s;
    logic [DATA_WIDTH-1:0] rd_m_s, rd_e_s, rd_n_s;
    logic                  all_m_s, all_e_s, all_n_s;
    logic                  lsw_m_s, lsw_e_s, lsw_n_s;
    logic                  go_ok_s, unused_flags_s;
    logic                  load_s, clear_s, start_s, busy_s, wr_ready_s, go_err_s, done_s;

    // wr_ready is a register that is only high in IDLE, so writes never hit a stream.
    assign wr_fire_s = wr_valid & wr_ready;
    assign wr_en_m_s = wr_fire_s & (wr_sel == SEL_M);
    assign wr_en_e_s = wr_fire_s & (wr_sel == SEL_E);
    assign wr_en_n_s = wr_fire_s & (wr_sel == SEL_N);

    operand_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_WORDS(NUM_WORDS)) u_bank_m (
        .clk(clk), .reset(reset), .wr_en(wr_en_m_s), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear(clear_s), .rd_addr(rd_addr_s), .rd_data(rd_m_s), .all_valid(all_m_s), .lsw_valid(lsw_m_s)
    );
    operand_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_WORDS(NUM_WORDS)) u_bank_e (
        .clk(clk), .reset(reset), .wr_en(wr_en_e_s), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear(clear_s), .rd_addr(rd_addr_s), .rd_data(rd_e_s), .all_valid(all_e_s), .lsw_valid(lsw_e_s)
    );
    operand_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_WORDS(NUM_WORDS)) u_bank_n (
        .clk(clk), .reset(reset), .wr_en(wr_en_n_s), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear(clear_s), .rd_addr(rd_addr_s), .rd_data(rd_n_s), .all_valid(all_n_s), .lsw_valid(lsw_n_s)
    );

`ifdef MONPRO_LOADER_ZERO_FILL_EN
    assign go_ok_s        = lsw_m_s & lsw_e_s & lsw_n_s;
    assign unused_flags_s = all_m_s & all_e_s & all_n_s;
`else
    assign go_ok_s        = all_m_s & all_e_s & all_n_s;
    assign unused_flags_s = lsw_m_s & lsw_e_s & lsw_n_s;
`endif

    // Next state, stream index and next values of every registered output.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        rd_addr_s  = {ADDR_WIDTH{1'b0}};
        load_s     = 1'b0;
        clear_s    = 1'b0;
        start_s    = 1'b0;
        busy_s     = 1'b0;
        wr_ready_s = 1'b1;
        go_err_s   = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    if (go_ok_s) begin
                        state_s    = ST_PRIME;
                        start_s    = 1'b1;
                        busy_s     = 1'b1;
                        wr_ready_s = 1'b0;
                    end else begin
                        go_err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRIME: begin
                // Fetch word 0 so it is on the outputs in the first STREAM cycle.
                state_s    = ST_STREAM;
                idx_s      = {ADDR_WIDTH{1'b0}};
                rd_addr_s  = {ADDR_WIDTH{1'b0}};
                load_s     = 1'b1;
                start_s    = 1'b1;
                busy_s     = 1'b1;
                wr_ready_s = 1'b0;
                go_err_s   = go;
            end
            ST_STREAM: begin
                go_err_s = go;
                if (idx_r == LAST_IDX) begin
                    state_s = ST_IDLE;
                    idx_s   = {ADDR_WIDTH{1'b0}};
                    done_s  = 1'b1;
                    clear_s = 1'b1;
                end else begin
                    // idx_r is the word on the outputs now; prefetch the next one.
                    state_s    = ST_STREAM;
                    idx_s      = idx_r + ONE_IDX;
                    rd_addr_s  = idx_s;
                    load_s     = 1'b1;
                    start_s    = 1'b1;
                    busy_s     = 1'b1;
                    wr_ready_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // State, index and output registers; reset forces everything idle at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= {ADDR_WIDTH{1'b0}};
            wr_ready    <= 1'b1;
            go_err      <= 1'b0;
            busy        <= 1'b0;
            start_input <= 1'b0;
            m_input     <= {DATA_WIDTH{1'b0}};
            e_input     <= {DATA_WIDTH{1'b0}};
            n_input     <= {DATA_WIDTH{1'b0}};
            stream_done <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            wr_ready    <= wr_ready_s;
            go_err      <= go_err_s;
            busy        <= busy_s;
            start_input <= start_s;
            m_input     <= load_s ? rd_m_s : {DATA_WIDTH{1'b0}};
            e_input     <= load_s ? rd_e_s : {DATA_WIDTH{1'b0}};
            n_input     <= load_s ? rd_n_s : {DATA_WIDTH{1'b0}};
            stream_done <= done_s;
        end
    end

endmodule

// File: doc/monpro_operand_loader.md
Name: monpro_operand_loader

Overview:
- Upstream feeder for the Montgomery exponentiation core (MonPro). Buffers the 1024-bit ciphertext m, private exponent e and modulus n as 32-bit words from a host write port.
- On command, streams the three operands word-parallel, least-significant word first, one word per clock on m_input/e_input/n_input, framed by start_input.

Parameters:
- DATA_WIDTH, 32, operand word width.
- ADDR_WIDTH, 5, word index width.
- NUM_WORDS, 32, words per operand; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready at a rising edge.
- wr_sel  in  2  target operand: 0=m, 1=e, 2=n, 3=reserved (accepted and discarded).
- wr_addr  in  ADDR_WIDTH  word index; 0 is the LSW.
- wr_data  in  DATA_WIDTH  word value.
- go  in  1  single-cycle request to start streaming.
- go_err  out  1  one-cycle pulse: go was rejected.
- busy  out  1  high in PRIME and STREAM.
- start_input  out  1  MonPro start/framing.
- m_input  out  DATA_WIDTH  streamed ciphertext word.
- e_input  out  DATA_WIDTH  streamed exponent word.
- n_input  out  DATA_WIDTH  streamed modulus word.
- stream_done  out  1  one-cycle pulse after the last word.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the system):
  - state=IDLE; all outputs 0 except wr_ready=1.
  - Valid bitmaps cleared. Buffer contents undefined.
- Storage: three NUM_WORDS x DATA_WIDTH banks, each with a NUM_WORDS-bit valid bitmap. An accepted write stores data and sets the valid bit. Rewriting an address overwrites it.
- States: IDLE, PRIME, STREAM.
- IDLE:
  - wr_ready=1.
  - On go: evaluate the bitmaps including any write accepted in the same cycle.
    - All 3*NUM_WORDS bits set: next state PRIME.
    - Otherwise: go_err=1 next cycle, stay IDLE.
- PRIME (1 cycle): start_input=1, data outputs 0, wr_ready=0. Next state STREAM, idx=0.
- STREAM:
  - Each cycle, start_input=1 and m/e/n_input = bank[idx], driven from registers.
  - idx increments per cycle. Exactly NUM_WORDS cycles.
  - After idx=NUM_WORDS-1: next cycle state=IDLE, start_input=0, data outputs 0, stream_done=1, all bitmaps cleared.
- Latency: go accepted at edge k → start_input high from k+1 → word 0 at k+2 → word 31 at k+33 → stream_done at k+34.
- Writes: wr_ready=0 in PRIME/STREAM, so writes are stalled, not dropped. go outside IDLE → go_err pulse, no effect on the stream.
- Back-to-back: go may be accepted in the stream_done cycle only if all three banks were fully rewritten in that cycle (normally impossible, so go_err).
- Reset mid-stream: immediate return to IDLE. start_input drops asynchronously; a partial stream is abandoned.
- No arithmetic. idx wraps only at the terminal word.

Optional Feature:
- Macro: MONPRO_LOADER_ZERO_FILL_EN.
- Defined:
  - go requires only that valid bit 0 of every bank is set; unwritten words stream as 0.
  - Each write also clears the valid bits of all higher addresses in that bank. This allows short m/e, e.g. m=5, e=0x10001.
- Undefined: full bitmap required as described; unwritten-word data is never streamed.

Decomposition:
- Shared package monpro_pkg:
  - DATA_WIDTH, ADDR_WIDTH, NUM_WORDS constants.
  - Operand-select encoding (SEL_M, SEL_E, SEL_N).
  - Loader state encoding.
- Sub-module operand_bank: one NUM_WORDS x DATA_WIDTH register file with write port, async-read port, valid bitmap, all_valid/lsw_valid flags and bitmap clear. Instantiated three times.

Test Plan:
- Load all 96 words (n word0=0x8B9496E5 … word31=0xA938A368; m word0=0x00000005, rest 0; e word0=0x00010001, rest 0), go → start_input high 33 cycles. Cycle k+2 shows n/m/e = 0x8B9496E5/0x5/0x10001; cycle k+33 shows n=0xA938A368; stream_done at k+34; busy low afterwards.
- Leave n word 17 unwritten, go → go_err=1 one cycle later, state stays IDLE, start_input stays 0. Without ZERO_FILL_EN the same case is rejected; with it defined, go is accepted and word 17 streams as 0.
- During STREAM hold wr_valid with sel=n, addr=0, data=0xFFFFFFFF → wr_ready=0 throughout. Streamed n word0 is unchanged. The write completes the first cycle after stream_done.
- Assert reset low at stream word 10 → outputs 0 and start_input=0 immediately. After release, go → go_err (bitmaps cleared).
- Write the last missing word and pulse go in the same cycle → stream starts (PRIME the next cycle).
- With ZERO_FILL_EN: write m=5, e=0x10001, all n, go → m/e words 1..31 stream as 0x00000000.
